// File: rtl/act_skew_feeder.sv
// Activation feeder for the PE array: accepts one vector per handshake, skews it
// diagonally across rows, drains zero vectors to flush the array, and drives pe_en.
module act_skew_feeder #(
    parameter int NUM_ROWS  = 16,
    parameter int DATA_W    = 32,
    parameter int DRAIN_CYC = 31,
    parameter int LEN_W     = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       start,
    input  logic [LEN_W-1:0]           vec_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_ROWS*DATA_W-1:0] in_vec,
    output logic [NUM_ROWS*DATA_W-1:0] active_left,
    output logic                       pe_en,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(DRAIN_CYC > 0 ? DRAIN_CYC - 1 : 0);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] drain_q, drain_d;
    logic             adv;
    logic             fin_q, fin_d;
    logic             done_q, done_d;
    logic             pe_en_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        adv     = 1'b0;
        fin_d   = 1'b0;
        done_d  = fin_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (vec_len != '0) begin
                        state_d = STREAM;
                        len_d   = vec_len;
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (in_valid) begin
                    adv   = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        drain_d = '0;
                        if (DRAIN_CYC == 0) begin
                            state_d = IDLE;
                            fin_d   = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                adv     = 1'b1;
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // fin_q marks the final pe_en cycle; done follows it so the array finishes its last step
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            pe_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
            pe_en_q <= adv;
        end
    end

    // Row r is a delay line of r+1 stages; stage 0 takes new data (or zero while draining)
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        logic [DATA_W-1:0] sr_q [0:r];

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                for (int s = 0; s <= r; s++) begin
                    sr_q[s] <= '0;
                end
            end else if (adv) begin
                sr_q[0] <= (state_q == STREAM) ? in_vec[r*DATA_W +: DATA_W] : '0;
                for (int s = 1; s <= r; s++) begin
                    sr_q[s] <= sr_q[s-1];
                end
            end
        end

        assign active_left[r*DATA_W +: DATA_W] = sr_q[r];
    end

    assign in_ready = (state_q == STREAM);
    assign busy     = (state_q != IDLE);
    assign pe_en    = pe_en_q;
    assign done     = done_q;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder: jobs push expected skewed vectors and done
// events into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_act_skew_feeder;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int DC = 3;
    localparam int LW = 16;
    localparam int VW = NR * DW;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          start;
    logic [LW-1:0] vec_len;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_vec;
    logic [VW-1:0] active_left;
    logic          pe_en;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    logic [VW-1:0] exp_q[$];
    int            done_exp[$];
    logic [VW-1:0] cur_vecs[$];

    logic [VW-1:0] prev_al;
    logic          prev_pe;
    int            de;

    always #5 CLK = ~CLK;

    act_skew_feeder #(
        .NUM_ROWS (NR),
        .DATA_W   (DW),
        .DRAIN_CYC(DC),
        .LEN_W    (LW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .vec_len    (vec_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .active_left(active_left),
        .pe_en      (pe_en),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: after advance k, lane r carries element r of vector k-r, zero outside the job
    function automatic logic [VW-1:0] model_vec(input int k, input int len);
        logic [VW-1:0] res;
        logic [VW-1:0] v;
        res = '0;
        for (int r = 0; r < NR; r++) begin
            if (k - r >= 0 && k - r < len) begin
                v = cur_vecs[k - r];
                res[r*DW +: DW] = v[r*DW +: DW];
            end
        end
        return res;
    endfunction

    always @(negedge CLK) begin
        if (!RESET) begin
            prev_al = '0;
            prev_pe = 1'b0;
        end else begin
            if (exp_q.size() == 0)
                check("idle_pe_en", VW'(pe_en), VW'(0));
            else if (pe_en)
                check("active_left", active_left, exp_q.pop_front());
            if (!pe_en)
                check("frozen_active_left", active_left, prev_al);
            if (done_exp.size() == 0)
                check("idle_done", VW'(done), VW'(0));
            else if (done) begin
                de = done_exp.pop_front();
                check("done_after_last_pe_en", VW'(prev_pe), VW'(de));
                if (de == 1)
                    check("done_all_drained", VW'(exp_q.size()), VW'(0));
            end
            prev_al = active_left;
            prev_pe = pe_en;
        end
    end

    task automatic fill_random(input int len);
        cur_vecs.delete();
        for (int i = 0; i < len; i++)
            cur_vecs.push_back({$urandom, $urandom});
    endtask

    task automatic wait_complete();
        int c;
        for (c = 0; c < 400; c++) begin
            if (exp_q.size() == 0 && done_exp.size() == 0) break;
            @(posedge CLK);
        end
        check("job_complete_pending", VW'(exp_q.size() + done_exp.size()), VW'(0));
        exp_q.delete();
        done_exp.delete();
        @(posedge CLK); #1;
    endtask

    task automatic run_job(input int len, input int stall_at, input int stall_n,
                           input bit rnd, input bit mid_start, input bit abort);
        int  i;
        int  budget;
        int  stalls;
        bit  acc;
        bit  stall;
        if (len > 0)
            for (int k = 0; k < len + DC; k++)
                exp_q.push_back(model_vec(k, len));
        done_exp.push_back(len > 0 ? 1 : 0);

        @(posedge CLK); #1;
        start   = 1'b1;
        vec_len = LW'(len);
        @(posedge CLK); #1;
        start   = 1'b0;
        vec_len = LW'($urandom);
        check("busy_after_start", VW'(busy), VW'(len > 0));

        if (len == 0) begin
            repeat (3) begin
                check("zero_len_in_ready", VW'(in_ready), VW'(0));
                @(posedge CLK); #1;
            end
        end else begin
            i = 0; budget = 0; stalls = 0;
            while (i < len && budget < 1000) begin
                stall = (rnd && $urandom_range(0, 3) == 0) ||
                        (i == stall_at && stalls < stall_n);
                if (i == stall_at && stall) stalls++;
                if (stall) begin
                    in_valid = 1'b0;
                    in_vec   = {$urandom, $urandom};
                end else begin
                    in_valid = 1'b1;
                    in_vec   = cur_vecs[i];
                end
                if (mid_start && i == 1) begin
                    start   = 1'b1;
                    vec_len = LW'($urandom_range(1, 9));
                end
                @(negedge CLK);
                acc = in_valid && in_ready;
                @(posedge CLK); #1;
                start = 1'b0;
                if (acc) i++;
                budget++;
            end
            in_valid = 1'b0;
            check("all_vectors_accepted", VW'(i), VW'(len));
        end

        if (abort) begin
            RESET = 1'b0;
            #1;
            check("abort_active_left", active_left, '0);
            check("abort_pe_en", VW'(pe_en), VW'(0));
            check("abort_busy", VW'(busy), VW'(0));
            check("abort_in_ready", VW'(in_ready), VW'(0));
            exp_q.delete();
            done_exp.delete();
            repeat (2) @(posedge CLK);
            #1 RESET = 1'b1;
            repeat (6) @(posedge CLK);
            #1;
        end else begin
            wait_complete();
        end
    endtask

    initial begin
        RESET    = 1'b0;
        start    = 1'b0;
        vec_len  = '0;
        in_valid = 1'b0;
        in_vec   = '0;

        repeat (3) begin
            @(posedge CLK); #1;
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            vec_len  = LW'($urandom);
            in_vec   = {$urandom, $urandom};
            #1;
            check("reset_active_left", active_left, '0);
            check("reset_outputs", VW'({pe_en, done, busy, in_ready}), VW'(0));
        end
        start    = 1'b0;
        in_valid = 1'b0;
        RESET    = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            in_valid = 1'($urandom);
            check("post_reset_active_left", active_left, '0);
            check("post_reset_outputs", VW'({pe_en, done, busy, in_ready}), VW'(0));
        end
        in_valid = 1'b0;

        cur_vecs.delete();
        cur_vecs.push_back({16'd4, 16'd3, 16'd2, 16'd1});
        run_job(1, -1, 0, 1'b0, 1'b0, 1'b0);

        fill_random(3);
        run_job(3, -1, 0, 1'b0, 1'b0, 1'b0);
        run_job(3, 1, 2, 1'b0, 1'b0, 1'b0);

        run_job(0, -1, 0, 1'b0, 1'b0, 1'b0);

        fill_random(4);
        run_job(4, -1, 0, 1'b0, 1'b1, 1'b0);

        fill_random(2);
        run_job(2, -1, 0, 1'b0, 1'b0, 1'b1);
        fill_random(3);
        run_job(3, -1, 0, 1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 8; j++) begin
            int len;
            len = $urandom_range(1, 7);
            fill_random(len);
            run_job(len, -1, 0, 1'b1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
